// File: rtl/tick_interval_meter_pkg.sv
// Shared FSM encoding and counter limits for the tick interval meter.
package tick_interval_meter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    localparam int COUNT_BITS_DEF = 16;

    // Saturation value of a COUNT_BITS-wide interval counter.
    function automatic logic [31:0] count_max(input int bits);
        return (bits >= 32) ? 32'hFFFF_FFFF : (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/tick_interval_meter_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for pulse inputs.
// prev resets high so a level already high at reset release is not an edge.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q && !prev_q;

endmodule

// File: rtl/tick_interval_meter.sv
// Measures clocks between consecutive rising edges of tick_in and presents
// each interval (or a timeout) on a valid/ready result register.
module tick_interval_meter
    import tick_interval_meter_pkg::*;
#(
    parameter int COUNT_BITS = COUNT_BITS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tick_in,
    output logic [COUNT_BITS-1:0] period,
    output logic                  period_timeout,
    output logic                  period_overrun,
    output logic                  period_valid,
    input  logic                  period_ready
);

    localparam logic [COUNT_BITS-1:0] CNT_MAX = COUNT_BITS'(count_max(COUNT_BITS));
    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    logic tick_rise;

    state_e                state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;

    logic                  res_vld;
    logic                  res_to;

    logic [COUNT_BITS-1:0] period_q, period_d;
    logic                  timeout_q, timeout_d;
    logic                  overrun_q, overrun_d;
    logic                  valid_q, valid_d;

    sync_edge_detect u_sync_edge (
        .clock  (clock),
        .reset  (reset),
        .d_i    (tick_in),
        .rise_o (tick_rise)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
        end
    end

    // An edge always wins over saturation, so a max-length interval that
    // ends exactly on time is reported as a normal result.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        res_vld = 1'b0;
        res_to  = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_rise) begin
                        count_d = CNT_ONE;
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (tick_rise) begin
                        res_vld = 1'b1;
                        count_d = CNT_ONE;
                    end else if (count_q == CNT_MAX) begin
                        res_vld = 1'b1;
                        res_to  = 1'b1;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // The result value is the count at the instant of the edge (or CNT_MAX
    // on timeout, which is the same register value).
    always_comb begin
        period_d  = period_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        valid_d   = valid_q;
        if (res_vld) begin
            period_d  = count_q;
            timeout_d = res_to;
            overrun_d = valid_q && !period_ready;
            valid_d   = 1'b1;
        end else if (valid_q && period_ready) begin
            valid_d = 1'b0;
        end
    end

    assign period         = period_q;
    assign period_timeout = timeout_q;
    assign period_overrun = overrun_q;
    assign period_valid   = valid_q;

endmodule

// File: doc/tick_interval_meter.md
Name: tick_interval_meter

Overview:
Measures the number of clock cycles between consecutive rising edges of a periodic pulse input. It is the receive-side counterpart of the prescaler tick generator and is used to check tick rates and measure external strobes (vsync, encoder pulses). Each completed interval is presented on a valid/ready output with timeout and overrun flags.

Parameters:
COUNT_BITS, 16, width of the interval counter and the period output; the maximum measurable period is 2^COUNT_BITS-1 clocks.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  measurement enable; low forces IDLE
tick_in  input  1  pulse to measure; may be asynchronous to clock
period  output  COUNT_BITS  measured interval in clocks
period_timeout  output  1  this result is a timeout, not a true interval
period_overrun  output  1  at least one earlier result was overwritten before being accepted
period_valid  output  1  result held and stable until accepted
period_ready  input  1  consumer accepts the result when valid && ready at a clock edge

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Counter goes to 0 and both sync flops go to 0.
  - The edge-detect "previous" register goes to 1, so a tick_in already high when reset deasserts does not count as an edge.
  - Reset mid-measurement discards the partial count and any pending result.
- Input path:
  - tick_in passes through a 2-flop synchronizer.
  - edge = sync2 && !prev, with prev <= sync2 every cycle.
  - The minimum distinguishable period is 2 clocks.
- FSM states: IDLE, MEASURE.
  - IDLE: on edge, counter <= 1 and go to MEASURE. No result is produced.
  - MEASURE, edge: result <= counter, counter <= 1, stay in MEASURE. The counted value equals the clock distance between the two detected edges.
  - MEASURE, no edge, counter < 2^COUNT_BITS-1: counter <= counter+1.
  - MEASURE, no edge, counter == 2^COUNT_BITS-1: result is all-ones with timeout=1, go to IDLE. The next edge restarts measurement without producing a result.
  - MEASURE, edge in the same cycle the counter is at max: the edge wins, giving a normal result of all-ones with timeout=0, and the FSM stays in MEASURE.
  - enable low: go to IDLE and clear counter in the same cycle. A pending output result is retained.
- Output register and handshake:
  - A new result loads period/period_timeout and sets period_valid=1.
  - If valid && !ready when a new result arrives: overwrite the result and set period_overrun=1.
  - If valid && ready in the same cycle a new result arrives: load the new result, valid stays 1, overrun=0.
  - If valid && ready with no new result: valid <= 0. Flags hold their values but are don't-care while valid is low.
  - The outputs are stable while valid && !ready, except when overwritten as above.
- Latency: period_valid rises on the 3rd rising clock edge, counting the edge that first samples the second tick_in high.
- Arithmetic: the counter saturates and never wraps.

Decomposition:
- Shared package: FSM state enum (ST_IDLE, ST_MEASURE) and a COUNT_MAX localparam derived from COUNT_BITS.
- One sub-module, sync_edge_detect: the 2-flop synchronizer plus rising-edge detector, with prev reset to 1. It is reusable by other pulse-input blocks.

Test Plan:
1. Drive tick_in from a prescaler tick generator with SCALE=1000, with period_ready=1 -> the first result arrives after the second tick; every result is period=1000, timeout=0, overrun=0.
2. tick_in pulses 2 clocks apart (1-clock-high pulses) -> period=2. A tick_in held high continuously after the first edge -> no further results; timeout after 65535 clocks.
3. COUNT_BITS=4, with a single edge and then no further edges -> after 15 counted clocks, period=15 and timeout=1, FSM in IDLE. The next two edges 5 clocks apart -> period=5, timeout=0.
4. period_ready=0 with three intervals of 10, 20, 30 -> valid stays high and the final held result is period=30, overrun=1. Raise ready for 1 cycle -> valid drops; the next interval gives overrun=0.
5. Result arrives in the same cycle as valid && ready -> valid stays 1, the new period is loaded, overrun=0.
6. Reset asserted mid-measurement, and tick_in high across reset release -> no false edge, no result. enable low mid-measurement -> the partial count is discarded and the pending result is kept.
